// File: rtl/distribution_writer.sv
// Streams a 256-bit distribution word to external SSR memory as one SPI mode-0 frame:
// command byte, 16-bit address, then the data word, MSB first, stalling the core throughout.
module distribution_writer #(
    parameter int         CLK_DIV   = 2,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         DWCtrl,
    input  logic [31:0]  rs1,
    input  logic [255:0] DW_input,
    output logic         dw_clk_stall,
    output logic         dw_done,
    output logic         spi_cs_n,
    output logic         spi_sclk,
    output logic         spi_mosi
);

    localparam int               FRAME_BITS = 8 + 16 + 256;
    localparam int               HALF_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
    localparam logic [8:0]       LAST_BIT   = 9'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_HOLD
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [FRAME_BITS-1:0]   w_shift_next;
    logic [8:0]              r_bit_cnt;
    logic [8:0]              w_bit_cnt_next;
    logic [HALF_W-1:0]       r_half_cnt;
    logic [HALF_W-1:0]       w_half_cnt_next;
    logic                    w_half_done;

    logic                    r_cs_n;
    logic                    r_sclk;
    logic                    r_mosi;
    logic                    r_stall;
    logic                    r_done;
    logic                    w_cs_n_next;
    logic                    w_sclk_next;
    logic                    w_mosi_next;
    logic                    w_stall_next;
    logic                    w_done_next;

    // Upper address half is not part of the frame.
    logic                    w_unused_rs1_hi;
    assign w_unused_rs1_hi = ^rs1[31:16];

    assign w_half_done = (r_half_cnt == HALF_LAST);

    // State register: every output is registered alongside the FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_half_cnt <= '0;
            r_cs_n     <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_stall    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_half_cnt <= w_half_cnt_next;
            r_cs_n     <= w_cs_n_next;
            r_sclk     <= w_sclk_next;
            r_mosi     <= w_mosi_next;
            r_stall    <= w_stall_next;
            r_done     <= w_done_next;
        end
    end

    // Next-state and datapath.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (DWCtrl) begin
                    w_state_next   = ST_SHIFT_LO;
                    w_shift_next   = {CMD_WRITE, rs1[15:0], DW_input};
                    w_bit_cnt_next = '0;
                end
            end
            ST_SHIFT_LO: begin
                if (w_half_done) begin
                    w_state_next = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (w_half_done) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next = ST_HOLD;
                    end else begin
                        w_state_next   = ST_SHIFT_LO;
                        w_shift_next   = {r_shift[FRAME_BITS-2:0], 1'b0};
                        w_bit_cnt_next = r_bit_cnt + 9'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (w_half_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Half-period timer restarts on every state change and rests at zero in IDLE.
        if ((w_state_next != r_state) || (r_state == ST_IDLE)) begin
            w_half_cnt_next = '0;
        end else begin
            w_half_cnt_next = r_half_cnt + HALF_W'(1);
        end
    end

    // Outputs are decoded from the upcoming state so they change on the same edge as it.
    always_comb begin
        w_cs_n_next  = (w_state_next == ST_IDLE);
        w_sclk_next  = (w_state_next == ST_SHIFT_HI);
        w_mosi_next  = (w_state_next == ST_IDLE) ? 1'b0 : w_shift_next[FRAME_BITS-1];
        w_stall_next = (w_state_next != ST_IDLE);
        w_done_next  = (r_state == ST_HOLD) && (w_state_next == ST_IDLE);
    end

    assign spi_cs_n     = r_cs_n;
    assign spi_sclk     = r_sclk;
    assign spi_mosi     = r_mosi;
    assign dw_clk_stall = r_stall;
    assign dw_done      = r_done;

endmodule
